fast_cmd_encoder: RTL and testbench



---
 rtl/fast_cmd_pkg.sv | 39 +++
 rtl/fast_cmd_encoder_frame_select.sv | 70 +++++++
 rtl/fast_cmd_encoder.sv | 127 ++++++++++++
 tb/tb_fast_cmd_encoder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fast_cmd_pkg.sv
// Shared fast-command definitions for the encoder and the decoder bench.
// The frame is 8 bits sent MSB first: header 110, 4-bit flag, stop bit 1.
// The request index constants give the bit order of pending/consume vectors.
package fast_cmd_pkg;

  localparam logic [2:0] HEADER    = 3'b110;
  localparam logic       STOP      = 1'b1;
  localparam int         FRAME_LEN = 8;

  // Bit positions inside the pending-request and consume vectors
  localparam int NUM_REQ     = 7;
  localparam int REQ_OS      = 0;  // OrbitSync
  localparam int REQ_L1A_NRM = 1;  // L1A_Normal
  localparam int REQ_L1A_FUL = 2;  // L1A_Full
  localparam int REQ_OCR     = 3;  // OrbitCountReset
  localparam int REQ_CAL_REQ = 4;  // CalibrationReq
  localparam int REQ_CAL_L1A = 5;  // CalibrationL1A
  localparam int REQ_RESYNC  = 6;  // ReSync

  typedef enum logic [3:0] {
    FLAG_IDLE            = 4'b0000,
    FLAG_ORBIT_SYNC      = 4'b0001,
    FLAG_L1A_NORMAL      = 4'b0010,
    FLAG_L1A_NORMAL_OS   = 4'b0011,
    FLAG_L1A_FULL        = 4'b0100,
    FLAG_L1A_FULL_OS     = 4'b0101,
    FLAG_OCR             = 4'b0111,
    FLAG_CAL_REQ         = 4'b1000,
    FLAG_L1A_NORMAL_CAL  = 4'b1001,
    FLAG_L1A_FULL_CAL    = 4'b1010,
    FLAG_RESYNC_L1A_FULL = 4'b1011,
    FLAG_RESYNC          = 4'b1111
  } fast_flag_e;

  function automatic logic [7:0] build_frame(input logic [3:0] flag);
    return {HEADER, flag, STOP};
  endfunction

endpackage

// File: rtl/fast_cmd_encoder_frame_select.sv
// fast_cmd_frame_select: priority selection from pending requests to the
// flag of the next frame and the set of pending bits that frame consumes.
//   tx_en    in   1 = encode pending requests, 0 = Idle and consume nothing
//   pend     in   pending request bits (fast_cmd_pkg REQ_* order)
//   flag     out  flag for the frame being loaded
//   consume  out  pending bits cleared by this frame
//   orphan   out  CalibrationL1A dropped because no L1A was pending
module fast_cmd_frame_select
  import fast_cmd_pkg::*;
#(
  parameter bit ENABLE_RESYNC_L1A = 1'b1
) (
  input  logic               tx_en,
  input  logic [NUM_REQ-1:0] pend,
  output logic [3:0]         flag,
  output logic [NUM_REQ-1:0] consume,
  output logic               orphan
);

  fast_flag_e flag_sel;

  always_comb begin
    flag_sel = FLAG_IDLE;
    consume  = '0;
    orphan   = 1'b0;
    if (tx_en) begin
      if (pend[REQ_RESYNC]) begin
        if (ENABLE_RESYNC_L1A && pend[REQ_L1A_FUL]) begin
          flag_sel                 = FLAG_RESYNC_L1A_FULL;
          consume[REQ_RESYNC]      = 1'b1;
          consume[REQ_L1A_FUL]     = 1'b1;
        end else begin
          flag_sel                 = FLAG_RESYNC;
          consume[REQ_RESYNC]      = 1'b1;
        end
      end else if (pend[REQ_OCR]) begin
        // OCR implies an orbit boundary, so a pending OrbitSync is absorbed
        flag_sel                   = FLAG_OCR;
        consume[REQ_OCR]           = 1'b1;
        consume[REQ_OS]            = 1'b1;
      end else if (pend[REQ_L1A_FUL] || pend[REQ_L1A_NRM]) begin
        // Full outranks Normal; Normal stays pending for the next frame
        consume[REQ_L1A_FUL]       = pend[REQ_L1A_FUL];
        consume[REQ_L1A_NRM]       = ~pend[REQ_L1A_FUL];
        if (pend[REQ_CAL_L1A]) begin
          flag_sel = pend[REQ_L1A_FUL] ? FLAG_L1A_FULL_CAL : FLAG_L1A_NORMAL_CAL;
          consume[REQ_CAL_L1A]     = 1'b1;
        end else if (pend[REQ_OS]) begin
          flag_sel = pend[REQ_L1A_FUL] ? FLAG_L1A_FULL_OS : FLAG_L1A_NORMAL_OS;
          consume[REQ_OS]          = 1'b1;
        end else begin
          flag_sel = pend[REQ_L1A_FUL] ? FLAG_L1A_FULL : FLAG_L1A_NORMAL;
        end
      end else if (pend[REQ_OS]) begin
        flag_sel                   = FLAG_ORBIT_SYNC;
        consume[REQ_OS]            = 1'b1;
      end else if (pend[REQ_CAL_REQ]) begin
        flag_sel                   = FLAG_CAL_REQ;
        consume[REQ_CAL_REQ]       = 1'b1;
      end else if (pend[REQ_CAL_L1A]) begin
        // CalibrationL1A only has meaning alongside an L1A
        consume[REQ_CAL_L1A]       = 1'b1;
        orphan                     = 1'b1;
      end
    end
  end

  assign flag = flag_sel;

endmodule

// File: rtl/fast_cmd_encoder.sv
// fast_cmd_encoder: encodes fast-command requests into 8-bit frames
// (110 + flag + 1) shifted out MSB first, one frame per 8 clocks.
//   Clk_320_TS      in   320 MHz clock
//   n_rstExt        in   asynchronous active-low reset
//   tx_en           in   1 = encode pending requests, 0 = send Idle
//   req_*           in   single-cycle request pulses
//   command_tx      out  serial frame output
//   Clk_40_tx       out  40 MHz clock, rising with frame_start
//   frame_start     out  high while command_tx carries b7
//   tx_flag         out  flag of the frame being shifted
//   err_overflow    out  request hit an already pending, unconsumed bit
//   err_orphan_cal  out  CalibrationL1A dropped (no L1A pending)
module fast_cmd_encoder
  import fast_cmd_pkg::*;
#(
  parameter int unsigned FRAME_PHASE       = 0,
  parameter bit          ENABLE_RESYNC_L1A = 1'b1
) (
  input  logic       Clk_320_TS,
  input  logic       n_rstExt,
  input  logic       tx_en,
  input  logic       req_OrbitSync,
  input  logic       req_L1A_Normal,
  input  logic       req_L1A_Full,
  input  logic       req_OrbitCountReset,
  input  logic       req_CalibrationReq,
  input  logic       req_CalibrationL1A,
  input  logic       req_ReSync,
  output logic       command_tx,
  output logic       Clk_40_tx,
  output logic       frame_start,
  output logic [3:0] tx_flag,
  output logic       err_overflow,
  output logic       err_orphan_cal
);

  localparam logic [2:0] PHASE_INIT = 3'(FRAME_PHASE);

  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shreg_q, shreg_d;
  logic [3:0]         tx_flag_q, tx_flag_d;
  logic               frame_start_q, frame_start_d;
  logic               clk40_q, clk40_d;
  logic [NUM_REQ-1:0] pend_q, pend_d;
  logic               err_ov_q, err_ov_d;
  logic               err_orph_q, err_orph_d;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] sel_consume;
  logic [NUM_REQ-1:0] consume;
  logic [3:0]         sel_flag;
  logic               sel_orphan;
  logic               load;

  always_comb begin
    req              = '0;
    req[REQ_OS]      = req_OrbitSync;
    req[REQ_L1A_NRM] = req_L1A_Normal;
    req[REQ_L1A_FUL] = req_L1A_Full;
    req[REQ_OCR]     = req_OrbitCountReset;
    req[REQ_CAL_REQ] = req_CalibrationReq;
    req[REQ_CAL_L1A] = req_CalibrationL1A;
    req[REQ_RESYNC]  = req_ReSync;
  end

  fast_cmd_frame_select #(
    .ENABLE_RESYNC_L1A (ENABLE_RESYNC_L1A)
  ) u_select (
    .tx_en   (tx_en),
    .pend    (pend_q),
    .flag    (sel_flag),
    .consume (sel_consume),
    .orphan  (sel_orphan)
  );

  assign load = (bit_cnt_q == 3'(FRAME_LEN - 1));

  always_comb begin
    bit_cnt_d  = bit_cnt_q + 3'd1;
    consume    = load ? sel_consume : '0;
    // A request landing on the edge that consumes its bit re-arms it for a
    // later frame without counting as overflow.
    pend_d     = (pend_q & ~consume) | req;
    err_ov_d   = |(req & pend_q & ~consume);
    err_orph_d = load & sel_orphan;
    clk40_d    = ~bit_cnt_d[2];
    if (load) begin
      shreg_d       = build_frame(sel_flag);
      tx_flag_d     = sel_flag;
      frame_start_d = 1'b1;
    end else begin
      shreg_d       = {shreg_q[6:0], 1'b0};
      tx_flag_d     = tx_flag_q;
      frame_start_d = 1'b0;
    end
  end

  always_ff @(posedge Clk_320_TS or negedge n_rstExt) begin
    if (!n_rstExt) begin
      bit_cnt_q     <= PHASE_INIT;
      shreg_q       <= 8'h00;
      tx_flag_q     <= 4'h0;
      frame_start_q <= 1'b0;
      clk40_q       <= 1'b0;
      pend_q        <= '0;
      err_ov_q      <= 1'b0;
      err_orph_q    <= 1'b0;
    end else begin
      bit_cnt_q     <= bit_cnt_d;
      shreg_q       <= shreg_d;
      tx_flag_q     <= tx_flag_d;
      frame_start_q <= frame_start_d;
      clk40_q       <= clk40_d;
      pend_q        <= pend_d;
      err_ov_q      <= err_ov_d;
      err_orph_q    <= err_orph_d;
    end
  end

  assign command_tx     = shreg_q[7];
  assign Clk_40_tx      = clk40_q;
  assign frame_start    = frame_start_q;
  assign tx_flag        = tx_flag_q;
  assign err_overflow   = err_ov_q;
  assign err_orphan_cal = err_orph_q;

endmodule

// File: tb/tb_fast_cmd_encoder.sv
// Bench for fast_cmd_encoder: two instances (phase 0 with ReSync+L1A_Full
// merging, phase 3 without) driven by the same requests and checked every
// cycle against a frame-level reference model, plus directed frame checks.
module tb_fast_cmd_encoder;

  localparam int OS = 0, NRM = 1, FULL = 2, OCR = 3, CALR = 4, CAL = 5, RS = 6;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       tx_en;
  logic [6:0] req;

  logic [1:0] cmd, c40, fs, ov, orph;
  logic [3:0] flg [2];

  int total = 0;
  int bad   = 0;

  // reference model state, one slot per instance
  int         m_cnt   [2];
  logic [6:0] m_pend  [2];
  logic [7:0] m_frame [2];
  int         m_sent  [2];
  logic [3:0] m_flag  [2];
  logic       m_fs    [2];
  logic       m_c40   [2];
  logic       m_ov    [2];
  logic       m_orph  [2];

  logic [7:0] fr;
  logic       orph_seen;
  int         first_fs [2];

  always #5 clk = ~clk;

  fast_cmd_encoder #(.FRAME_PHASE(0), .ENABLE_RESYNC_L1A(1'b1)) u0 (
    .Clk_320_TS(clk), .n_rstExt(n_rst), .tx_en(tx_en),
    .req_OrbitSync(req[OS]), .req_L1A_Normal(req[NRM]), .req_L1A_Full(req[FULL]),
    .req_OrbitCountReset(req[OCR]), .req_CalibrationReq(req[CALR]),
    .req_CalibrationL1A(req[CAL]), .req_ReSync(req[RS]),
    .command_tx(cmd[0]), .Clk_40_tx(c40[0]), .frame_start(fs[0]), .tx_flag(flg[0]),
    .err_overflow(ov[0]), .err_orphan_cal(orph[0]));

  fast_cmd_encoder #(.FRAME_PHASE(3), .ENABLE_RESYNC_L1A(1'b0)) u1 (
    .Clk_320_TS(clk), .n_rstExt(n_rst), .tx_en(tx_en),
    .req_OrbitSync(req[OS]), .req_L1A_Normal(req[NRM]), .req_L1A_Full(req[FULL]),
    .req_OrbitCountReset(req[OCR]), .req_CalibrationReq(req[CALR]),
    .req_CalibrationL1A(req[CAL]), .req_ReSync(req[RS]),
    .command_tx(cmd[1]), .Clk_40_tx(c40[1]), .frame_start(fs[1]), .tx_flag(flg[1]),
    .err_overflow(ov[1]), .err_orphan_cal(orph[1]));

  function automatic int phase_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  function automatic bit resync_of(input int i);
    return (i == 0);
  endfunction

  // Frame content chosen from the pending set by the command priority list.
  function automatic void model_select(input logic [6:0] p, input logic en, input bit rsl,
                                       output logic [3:0] f, output logic [6:0] c,
                                       output logic o);
    f = 4'b0000; c = 7'd0; o = 1'b0;
    if (!en) return;
    if (p[RS]) begin
      if (p[FULL] && rsl) begin f = 4'b1011; c[RS] = 1; c[FULL] = 1; end
      else begin f = 4'b1111; c[RS] = 1; end
    end else if (p[OCR]) begin
      f = 4'b0111; c[OCR] = 1; c[OS] = 1;
    end else if (p[FULL]) begin
      c[FULL] = 1;
      if (p[CAL]) begin f = 4'b1010; c[CAL] = 1; end
      else if (p[OS]) begin f = 4'b0101; c[OS] = 1; end
      else f = 4'b0100;
    end else if (p[NRM]) begin
      c[NRM] = 1;
      if (p[CAL]) begin f = 4'b1001; c[CAL] = 1; end
      else if (p[OS]) begin f = 4'b0011; c[OS] = 1; end
      else f = 4'b0010;
    end else if (p[OS]) begin
      f = 4'b0001; c[OS] = 1;
    end else if (p[CALR]) begin
      f = 4'b1000; c[CALR] = 1;
    end else if (p[CAL]) begin
      c[CAL] = 1; o = 1'b1;
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = phase_of(i); m_pend[i] = 7'd0; m_frame[i] = 8'h00; m_sent[i] = 8;
      m_flag[i] = 4'h0; m_fs[i] = 0; m_c40[i] = 0; m_ov[i] = 0; m_orph[i] = 0;
    end
  endfunction

  function automatic void model_edge(input logic [6:0] r, input logic en);
    logic [3:0] f;
    logic [6:0] c;
    logic       o;
    bit         is_load;
    for (int i = 0; i < 2; i++) begin
      is_load = (m_cnt[i] == 7);
      f = m_flag[i]; c = 7'd0; o = 1'b0;
      if (is_load) model_select(m_pend[i], en, resync_of(i), f, c, o);
      m_ov[i]   = |(r & m_pend[i] & ~c);
      m_pend[i] = (m_pend[i] & ~c) | r;
      m_orph[i] = o;
      m_fs[i]   = is_load;
      if (is_load) begin
        m_frame[i] = {3'b110, f, 1'b1}; m_sent[i] = 0; m_flag[i] = f;
      end else if (m_sent[i] < 8) begin
        m_sent[i]++;
      end
      m_cnt[i] = (m_cnt[i] + 1) % 8;
      m_c40[i] = (m_cnt[i] < 4);
    end
  endfunction

  task automatic chk(input string tag, input int inst, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s inst=%0d observed=%h expected=%h", tag, inst, obs, exp);
    end
  endtask

  task automatic check_all();
    logic line;
    for (int i = 0; i < 2; i++) begin
      line = (m_sent[i] < 8) ? m_frame[i][7 - m_sent[i]] : 1'b0;
      chk("command_tx",  i, {7'd0, cmd[i]},  {7'd0, line});
      chk("clk_40_tx",   i, {7'd0, c40[i]},  {7'd0, m_c40[i]});
      chk("frame_start", i, {7'd0, fs[i]},   {7'd0, m_fs[i]});
      chk("tx_flag",     i, {4'd0, flg[i]},  {4'd0, m_flag[i]});
      chk("err_overflow",i, {7'd0, ov[i]},   {7'd0, m_ov[i]});
      chk("err_orphan",  i, {7'd0, orph[i]}, {7'd0, m_orph[i]});
    end
  endtask

  task automatic step(input logic [6:0] r, input logic en);
    @(negedge clk);
    req   = r;
    tx_en = en;
    @(posedge clk);
    model_edge(r, en);
    #1;
    check_all();
  endtask

  // asynchronous reset asserted mid-cycle, released just after a rising edge
  task automatic do_reset();
    @(negedge clk);
    #2;
    n_rst = 1'b0;
    req   = 7'd0;
    model_reset();
    #1;
    check_all();
    chk("reset_cmd_zero", 0, {7'd0, cmd[0]}, 8'h00);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
  endtask

  // Waits for the next frame_start of one instance and captures its 8 bits.
  task automatic get_frame(input int inst, input logic en, output logic [7:0] f,
                           output logic o);
    int n;
    n = 0; f = 8'h00; o = 1'b0;
    do begin
      step(7'd0, en);
      n++;
    end while (fs[inst] !== 1'b1 && n < 16);
    chk("frame_start_seen", inst, {7'd0, fs[inst]}, 8'h01);
    o    = orph[inst];
    f[7] = cmd[inst];
    for (int b = 6; b >= 0; b--) begin
      step(7'd0, en);
      f[b] = cmd[inst];
    end
    $display("frame inst=%0d bits=%b flag=%b", inst, f, flg[inst]);
  endtask

  initial begin
    n_rst = 1'b0; tx_en = 1'b1; req = 7'd0;
    model_reset();
    #12;
    check_all();
    @(posedge clk);
    #1;
    n_rst = 1'b1;

    // 1: alignment after reset release, then idle frames
    first_fs[0] = -1; first_fs[1] = -1;
    for (int c = 1; c <= 16; c++) begin
      step(7'd0, 1'b1);
      for (int i = 0; i < 2; i++) if (fs[i] === 1'b1 && first_fs[i] < 0) first_fs[i] = c;
    end
    chk("first_fs_cycle", 0, 8'(first_fs[0]), 8'd8);
    chk("first_fs_cycle", 1, 8'(first_fs[1]), 8'd5);
    get_frame(0, 1'b1, fr, orph_seen);
    chk("idle_frame", 0, fr, 8'hC1);

    // 2: Normal + OrbitSync merged
    step((7'd1 << NRM) | (7'd1 << OS), 1'b1);
    get_frame(0, 1'b1, fr, orph_seen);
    chk("normal_os_frame", 0, fr, 8'hC7);
    chk("normal_os_flag", 0, {4'd0, flg[0]}, 8'h03);
    get_frame(0, 1'b1, fr, orph_seen);
    chk("after_normal_idle", 0, fr, 8'hC1);

    // 3: ReSync + Full, merged on inst0 and split on inst1
    step((7'd1 << RS) | (7'd1 << FULL), 1'b1);
    get_frame(0, 1'b1, fr, orph_seen);
    chk("resync_full_merged", 0, fr, 8'hD7);
    step((7'd1 << RS) | (7'd1 << FULL), 1'b1);
    get_frame(1, 1'b1, fr, orph_seen);
    chk("resync_alone", 1, fr, 8'hDF);
    get_frame(1, 1'b1, fr, orph_seen);
    chk("full_deferred", 1, fr, 8'hC9);
    get_frame(0, 1'b1, fr, orph_seen);

    // 4: orphan CalibrationL1A, then Cal with Full
    step(7'd1 << CAL, 1'b1);
    get_frame(0, 1'b1, fr, orph_seen);
    chk("orphan_idle_frame", 0, fr, 8'hC1);
    chk("orphan_pulse", 0, {7'd0, orph_seen}, 8'h01);
    step((7'd1 << CAL) | (7'd1 << FULL), 1'b1);
    get_frame(0, 1'b1, fr, orph_seen);
    chk("full_cal_frame", 0, fr, 8'hD5);

    // 5: Full before Normal, overflow on a repeated Full
    step((7'd1 << FULL) | (7'd1 << NRM), 1'b1);
    step(7'd1 << FULL, 1'b1);
    chk("overflow_pulse", 0, {7'd0, ov[0]}, 8'h01);
    get_frame(0, 1'b1, fr, orph_seen);
    chk("full_first", 0, fr, 8'hC9);
    get_frame(0, 1'b1, fr, orph_seen);
    chk("normal_second", 0, fr, 8'hC5);
    get_frame(0, 1'b1, fr, orph_seen);
    chk("single_full_only", 0, fr, 8'hC1);

    // 6: tx_en hold-off, then reset mid-frame
    step(7'd1 << OCR, 1'b0);
    for (int k = 0; k < 3; k++) begin
      get_frame(0, 1'b0, fr, orph_seen);
      chk("tx_en_low_idle", 0, fr, 8'hC1);
    end
    get_frame(0, 1'b1, fr, orph_seen);
    chk("ocr_frame", 0, fr, 8'hCF);
    step(7'd1 << OCR, 1'b1);
    for (int k = 0; k < 8; k++) step(7'd0, 1'b1);
    step(7'd1 << FULL, 1'b1);
    chk("mid_frame_high", 0, {7'd0, cmd[0]}, 8'h01);
    do_reset();
    get_frame(0, 1'b1, fr, orph_seen);
    chk("pending_lost", 0, fr, 8'hC1);

    // randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      logic [6:0] r;
      r = 7'd0;
      for (int b = 0; b < 7; b++) if ($urandom_range(0, 11) == 0) r[b] = 1'b1;
      if ($urandom_range(0, 249) == 0) do_reset();
      step(r, ($urandom_range(0, 9) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
